// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a note table in synchronous-read memory and drives the
// square-wave tone generator's freq / output_enable / volume inputs.
// Table word: [31] volume, [30:20] duration in ticks (0 ends the song),
// [19:0] frequency in Hz (0 is a rest).
// All outputs come straight from registers.
module tone_sequencer #(
    parameter int TICK_DIV  = 125000,
    parameter int GAP_TICKS = 5,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [31:0]       note_data,
    output logic [23:0]       freq,
    output logic              output_enable,
    output logic              volume,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Prescaler needs at least one bit even when TICK_DIV is 1.
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [10:0]     GAP_LEN    = 11'(GAP_TICKS);
    localparam bit              HAS_GAP    = (GAP_TICKS > 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         freq_q, freq_d;
    logic                oe_q, oe_d;
    logic                vol_q, vol_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [10:0]         dur_q, dur_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [10:0]         tick_q, tick_d;

    logic                presc_wrap;
    logic [10:0]         tick_inc;
    logic                end_of_song;
    logic                play_last;
    logic                gap_last;

    // Shared tick timing: the last cycle of a phase is the prescaler wrap
    // that brings the tick count up to the phase length.
    always_comb begin
        presc_wrap  = (presc_q == PRESC_LAST);
        tick_inc    = tick_q + 11'd1;
        end_of_song = (note_data[30:20] == 11'd0);
        play_last   = presc_wrap && (tick_inc == dur_q);
        gap_last    = presc_wrap && (tick_inc == GAP_LEN);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; stop overrides everything, including start.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    if (end_of_song) begin
                        // An end marker at address 0 is an empty song: never loop on it.
                        if (loop_en && (addr_q != '0)) state_d = S_FETCH;
                        else                           state_d = S_DONE;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY:  if (play_last) state_d = HAS_GAP ? S_GAP : S_FETCH;
                S_GAP:   if (gap_last) state_d = S_FETCH;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values, decided from the current state and the
    // transition being taken this cycle.
    always_comb begin
        addr_d  = addr_q;
        freq_d  = freq_q;
        oe_d    = oe_q;
        vol_d   = vol_q;
        dur_d   = dur_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        if (state_d == S_IDLE) begin
            addr_d  = '0;
            freq_d  = '0;
            oe_d    = 1'b0;
            vol_d   = 1'b0;
            dur_d   = '0;
            presc_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    oe_d   = 1'b0;
                end
                S_LATCH: begin
                    if (end_of_song) begin
                        oe_d = 1'b0;
                        if (state_d == S_FETCH) addr_d = '0;
                        else                    freq_d = '0;
                    end else begin
                        freq_d  = {4'd0, note_data[19:0]};
                        vol_d   = note_data[31];
                        oe_d    = (note_data[19:0] != 20'd0);
                        dur_d   = note_data[30:20];
                        presc_d = '0;
                        tick_d  = '0;
                    end
                end
                S_PLAY: begin
                    if (presc_wrap) begin
                        presc_d = '0;
                        tick_d  = tick_inc;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (play_last) begin
                        presc_d = '0;
                        tick_d  = '0;
                        oe_d    = 1'b0;
                        if (!HAS_GAP) addr_d = addr_q + ADDR_W'(1);
                    end
                end
                S_GAP: begin
                    if (presc_wrap) begin
                        presc_d = '0;
                        tick_d  = tick_inc;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (gap_last) begin
                        presc_d = '0;
                        tick_d  = '0;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            freq_q  <= '0;
            oe_q    <= 1'b0;
            vol_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dur_q   <= '0;
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            freq_q  <= freq_d;
            oe_q    <= oe_d;
            vol_q   <= vol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign note_addr     = addr_q;
    assign cur_addr      = addr_q;
    assign freq          = freq_q;
    assign output_enable = oe_q;
    assign volume        = vol_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: two instances (8-bit address with a 1-tick gap,
// 2-bit address legato), a cycle-level reference trace built from the note
// table, and a negedge monitor that pops and compares expected outputs.
module tb_tone_sequencer;

    localparam logic [43:0] M_ALL     = '1;
    localparam logic [43:0] VOL_BIT   = 44'd1 << 40;
    localparam logic [43:0] FREQ_BITS = 44'hFF_FFFF << 16;
    localparam logic [43:0] M_NOVOL   = M_ALL & ~VOL_BIT;
    localparam logic [43:0] M_NOFV    = M_ALL & ~VOL_BIT & ~FREQ_BITS;

    logic clk;
    logic rst_n;

    // Instance A: TICK_DIV=4, GAP_TICKS=1, ADDR_W=8
    logic        start_a, stop_a, loop_a;
    logic [7:0]  addr_a, cur_a;
    logic [31:0] data_a;
    logic [23:0] freq_a;
    logic        oe_a, vol_a, busy_a, done_a;
    logic [31:0] mem_a [0:255];

    // Instance B: TICK_DIV=2, GAP_TICKS=0, ADDR_W=2
    logic        start_b, stop_b, loop_b;
    logic [1:0]  addr_b, cur_b;
    logic [31:0] data_b;
    logic [23:0] freq_b;
    logic        oe_b, vol_b, busy_b, done_b;
    logic [31:0] mem_b [0:3];

    logic [43:0] exp_a_q[$];
    logic [43:0] msk_a_q[$];
    logic [43:0] exp_b_q[$];
    logic [43:0] msk_b_q[$];

    int errors = 0;
    int checks = 0;
    int obs_wraps_b = 0;
    logic [1:0] prev_addr_b = 2'd0;
    logic       prev_busy_b = 1'b0;

    // reference-model bookkeeping
    int   mdl_sel, mdl_max, mdl_n, mdl_wraps, mdl_last_addr, mdl_nent;
    logic mdl_last_busy;

    tone_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .loop_en(loop_a),
        .note_addr(addr_a), .note_data(data_a), .freq(freq_a), .output_enable(oe_a),
        .volume(vol_a), .busy(busy_a), .done(done_a), .cur_addr(cur_a)
    );

    tone_sequencer #(.TICK_DIV(2), .GAP_TICKS(0), .ADDR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .loop_en(loop_b),
        .note_addr(addr_b), .note_data(data_b), .freq(freq_b), .output_enable(oe_b),
        .volume(vol_b), .busy(busy_b), .done(done_b), .cur_addr(cur_b)
    );

    // clock / synchronous-read note memories
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_a <= mem_a[addr_a];
        data_b <= mem_b[addr_b];
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [43:0] e, m, act;
        if (exp_a_q.size() > 0) begin
            e   = exp_a_q.pop_front();
            m   = msk_a_q.pop_front();
            act = {busy_a, done_a, oe_a, vol_a, freq_a, addr_a, cur_a};
            checks++;
            if (((act ^ e) & m) !== 44'd0) begin
                errors++;
                $display("FAIL dut_a outputs t=%0t got=%h exp=%h mask=%h", $time, act, e, m);
            end
        end
        if (exp_b_q.size() > 0) begin
            e   = exp_b_q.pop_front();
            m   = msk_b_q.pop_front();
            act = {busy_b, done_b, oe_b, vol_b, freq_b, 6'd0, addr_b, 6'd0, cur_b};
            checks++;
            if (((act ^ e) & m) !== 44'd0) begin
                errors++;
                $display("FAIL dut_b outputs t=%0t got=%h exp=%h mask=%h", $time, act, e, m);
            end
            if (busy_b && addr_b == 2'd0 && prev_busy_b && prev_addr_b == 2'd3) obs_wraps_b++;
            prev_addr_b = addr_b;
            prev_busy_b = busy_b;
        end
    end

    // driver / model tasks
    task automatic push(input int sel, input logic [43:0] v, input logic [43:0] m);
        if (sel == 0) begin exp_a_q.push_back(v); msk_a_q.push_back(m); end
        else          begin exp_b_q.push_back(v); msk_b_q.push_back(m); end
    endtask

    task automatic push_idle(input int sel, input int n);
        repeat (n) push(sel, 44'd0, M_ALL);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? exp_a_q.size() : exp_b_q.size();
    endfunction

    task automatic emit(input logic b, input logic d, input logic oe, input logic v,
                        input logic [23:0] f, input int a, input logic [43:0] m);
        if (mdl_n >= mdl_max) return;
        mdl_n++;
        if (b && a == 0 && mdl_last_busy && mdl_last_addr == mdl_nent - 1) mdl_wraps++;
        mdl_last_addr = a;
        mdl_last_busy = b;
        push(mdl_sel, {b, d, oe, v, f, 8'(a), 8'(a)}, m);
    endtask

    // Reference trace: per table entry two silent fetch cycles, then
    // duration*TICK_DIV playing cycles and GAP_TICKS*TICK_DIV silent cycles.
    task automatic build_trace(input int sel, input bit lp, input int maxc);
        int td, gp, addr, dur;
        logic [31:0] w;
        logic [23:0] f;
        bit fin;
        td = (sel != 0) ? 2 : 4;
        gp = (sel != 0) ? 0 : 1;
        mdl_nent = (sel != 0) ? 4 : 256;
        mdl_sel = sel; mdl_max = maxc; mdl_n = 0; mdl_wraps = 0;
        mdl_last_addr = 0; mdl_last_busy = 1'b0;
        addr = 0; fin = 1'b0;
        while (!fin && mdl_n < maxc) begin
            emit(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, addr, M_NOFV);
            emit(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, addr, M_NOFV);
            w = (sel != 0) ? mem_b[addr] : mem_a[addr];
            dur = int'(w[30:20]);
            if (dur == 0) begin
                if (lp && addr != 0) addr = 0;
                else begin
                    emit(1'b1, 1'b1, 1'b0, 1'b0, 24'd0, addr, M_NOVOL);
                    repeat (3) emit(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 0, M_ALL);
                    fin = 1'b1;
                end
            end else begin
                f = {4'd0, w[19:0]};
                repeat (dur * td) emit(1'b1, 1'b0, (w[19:0] != 20'd0), w[31], f, addr, M_ALL);
                repeat (gp * td) emit(1'b1, 1'b0, 1'b0, 1'b0, f, addr, M_NOVOL);
                addr = (addr + 1) % mdl_nent;
            end
        end
    endtask

    task automatic wait_drain(input int sel, input string nm);
        int g = 0;
        while (qsize(sel) != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        if (qsize(sel) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: %0d entries left, need 0", nm, qsize(sel));
            if (sel == 0) begin exp_a_q.delete(); msk_a_q.delete(); end
            else          begin exp_b_q.delete(); msk_b_q.delete(); end
        end
    endtask

    task automatic set_ctl(input int sel, input logic s, input logic p);
        if (sel == 0) begin start_a = s; stop_a = p; end
        else          begin start_b = s; stop_b = p; end
    endtask

    task automatic run_song(input int sel, input bit lp, input int maxc, input bit do_stop);
        if (sel == 0) loop_a = lp; else loop_b = lp;
        obs_wraps_b = 0;
        @(posedge clk); #1;
        set_ctl(sel, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_ctl(sel, 1'b0, 1'b0);
        build_trace(sel, lp, maxc);
        wait_drain(sel, "song");
        if (do_stop) begin
            #1 set_ctl(sel, 1'b0, 1'b1);
            @(posedge clk); #1;
            set_ctl(sel, 1'b0, 1'b0);
            push_idle(sel, 3);
            wait_drain(sel, "stop");
        end
    endtask

    task automatic load_table_a();
        for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
        mem_a[0] = {1'b1, 11'd3, 20'd440};
        mem_a[1] = {1'b0, 11'd2, 20'd0};
        mem_a[2] = 32'd0;
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        int n;
        rst_n = 1'b0;
        start_a = 0; stop_a = 0; loop_a = 0;
        start_b = 0; stop_b = 0; loop_b = 0;
        for (int i = 0; i < 4; i++) mem_b[i] = 32'd0;
        load_table_a();
        push_idle(0, 2);
        push_idle(1, 2);
        #22 rst_n = 1'b1;
        push_idle(0, 2);
        push_idle(1, 2);
        wait_drain(0, "reset");
        wait_drain(1, "reset");

        // full song: 440 Hz note, rest, end marker
        run_song(0, 1'b0, 1000, 1'b0);
        // same song looping; stopped after it has replayed
        run_song(0, 1'b1, 70, 1'b1);
        // stop in the middle of the 440 Hz note
        run_song(0, 1'b0, 6, 1'b1);

        // start and stop together from IDLE: stays idle
        @(posedge clk); #1;
        start_a = 1'b1; stop_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; stop_a = 1'b0;
        push_idle(0, 3);
        wait_drain(0, "start_stop");

        // asynchronous reset during the first note's gap
        run_song(0, 1'b0, 15, 1'b0);
        #3 rst_n = 1'b0;
        push_idle(0, 1);
        #4 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 push_idle(0, 3);
        wait_drain(0, "after_reset");

        // empty song at address 0 with loop enabled: done, no loop
        mem_a[0] = 32'd0;
        run_song(0, 1'b1, 1000, 1'b0);

        // random songs
        for (int r = 0; r < 6; r++) begin
            bit lp;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                mem_a[i][31]    = 1'($urandom_range(0, 1));
                mem_a[i][30:20] = 11'($urandom_range(1, 3));
                mem_a[i][19:0]  = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF));
            end
            mem_a[n] = 32'd0;
            lp = 1'($urandom_range(0, 1));
            if (lp) run_song(0, 1'b1, 80, 1'b1);
            else    run_song(0, 1'b0, 1000, 1'b0);
        end

        // 2-bit address: four nonzero notes, address wraps 3->0 and keeps playing
        for (int i = 0; i < 4; i++) begin
            mem_b[i][31]    = 1'($urandom_range(0, 1));
            mem_b[i][30:20] = 11'($urandom_range(1, 3));
            mem_b[i][19:0]  = 20'($urandom_range(1, 20'hFFFFF));
        end
        run_song(1, 1'b0, 70, 1'b1);
        checks++;
        if (obs_wraps_b != mdl_wraps) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=%0d", obs_wraps_b, mdl_wraps);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
